// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the Y86 pipeline control unit: instruction codes,
// status codes, run-state encodings and the stage-control bundle.
package pipe_ctrl_pkg;

    typedef logic [3:0] icode_t;
    typedef logic [3:0] reg_t;
    typedef logic [2:0] stat_t;
    typedef logic [1:0] pcState_t;

    localparam icode_t I_HALT   = 4'h0;
    localparam icode_t I_NOP    = 4'h1;
    localparam icode_t I_RRMOVQ = 4'h2;
    localparam icode_t I_IRMOVQ = 4'h3;
    localparam icode_t I_RMMOVQ = 4'h4;
    localparam icode_t I_MRMOVQ = 4'h5;
    localparam icode_t I_OPQ    = 4'h6;
    localparam icode_t I_JXX    = 4'h7;
    localparam icode_t I_CALL   = 4'h8;
    localparam icode_t I_RET    = 4'h9;
    localparam icode_t I_PUSHQ  = 4'hA;
    localparam icode_t I_POPQ   = 4'hB;

    localparam reg_t R_NONE = 4'hF;

    localparam stat_t STAT_AOK = 3'd1;
    localparam stat_t STAT_HLT = 3'd2;
    localparam stat_t STAT_ADR = 3'd3;
    localparam stat_t STAT_INS = 3'd4;

    localparam pcState_t PC_INIT = 2'd0;
    localparam pcState_t PC_RUN  = 2'd1;
    localparam pcState_t PC_HALT = 2'd2;

    typedef struct packed {
        logic fStall;
        logic dStall;
        logic dBubble;
        logic eBubble;
        logic mBubble;
        logic wStall;
        logic setCc;
    } ctrl_t;

    // Everything frozen or bubbled; used during reset and the post-reset flush.
    localparam ctrl_t CTRL_FLUSH = '{fStall: 1'b1, dStall: 1'b0, dBubble: 1'b1,
                                     eBubble: 1'b1, mBubble: 1'b1, wStall: 1'b0,
                                     setCc: 1'b0};

    function automatic logic isLoad(input icode_t ic);
        return (ic == I_MRMOVQ) || (ic == I_POPQ);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline-stage inputs, stall/bubble controls and perf counters
// exchanged between the datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_ctrl_pkg::*;

    icode_t           D_icode_i;
    reg_t             d_srcA_i;
    reg_t             d_srcB_i;
    icode_t           E_icode_i;
    reg_t             E_dstM_i;
    logic             e_Cnd_i;
    icode_t           M_icode_i;
    stat_t            m_stat_i;
    stat_t            W_stat_i;

    logic             F_stall_o;
    logic             D_stall_o;
    logic             D_bubble_o;
    logic             E_bubble_o;
    logic             M_bubble_o;
    logic             W_stall_o;
    logic             set_cc_o;
    stat_t            cpu_stat_o;
    logic [CNT_W-1:0] cyc_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    modport master (
        output D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, e_Cnd_i,
               M_icode_i, m_stat_i, W_stat_i,
        input  F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o,
               W_stall_o, set_cc_o, cpu_stat_o, cyc_cnt_o, stall_cnt_o,
               mispred_cnt_o
    );

    modport slave (
        input  D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, e_Cnd_i,
               M_icode_i, m_stat_i, W_stat_i,
        output F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o,
               W_stall_o, set_cc_o, cpu_stat_o, cyc_cnt_o, stall_cnt_o,
               mispred_cnt_o
    );

endinterface

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86 pipeline control: hazard-driven stall/bubble generation, run-state
// sequencing (flush after reset, halt on exception) and hazard counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 5,
    parameter int CNT_W        = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    pipe_ctrl_if.slave bus
);

    localparam int            FW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    pcState_t      state_q;
    pcState_t      state_d;
    logic [FW-1:0] flushCnt_q;
    logic [FW-1:0] flushCnt_d;
    stat_t         cpuStat_q;
    stat_t         cpuStat_d;

    logic  loadUse;
    logic  mispred;
    logic  retHaz;
    logic  excHaz;
    logic  running;
    ctrl_t ctrl;

    always_comb begin
        state_d    = state_q;
        flushCnt_d = flushCnt_q;
        cpuStat_d  = cpuStat_q;
        case (state_q)
            PC_INIT: begin
                if (flushCnt_q == '0) begin
                    state_d = PC_RUN;
                end else begin
                    flushCnt_d = flushCnt_q - FW'(1);
                end
            end
            PC_RUN: begin
                if (bus.W_stat_i != STAT_AOK) begin
                    state_d   = PC_HALT;
                    cpuStat_d = bus.W_stat_i;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= PC_INIT;
            flushCnt_q <= FLUSH_LAST;
            cpuStat_q  <= STAT_AOK;
        end else begin
            state_q    <= state_d;
            flushCnt_q <= flushCnt_d;
            cpuStat_q  <= cpuStat_d;
        end
    end

    // A load/use stall takes priority over the RET bubble so D is held, not flushed.
    always_comb begin
        loadUse = isLoad(bus.E_icode_i) &&
                  ((bus.E_dstM_i == bus.d_srcA_i) || (bus.E_dstM_i == bus.d_srcB_i));
        mispred = (bus.E_icode_i == I_JXX) && !bus.e_Cnd_i;
        retHaz  = (bus.D_icode_i == I_RET) || (bus.E_icode_i == I_RET) ||
                  (bus.M_icode_i == I_RET);
        excHaz  = (bus.m_stat_i != STAT_AOK) || (bus.W_stat_i != STAT_AOK);
        ctrl    = CTRL_FLUSH;
        running = 1'b0;
        if (!rst_i) begin
            case (state_q)
                PC_RUN: begin
                    running      = 1'b1;
                    ctrl.fStall  = loadUse | retHaz;
                    ctrl.dStall  = loadUse;
                    ctrl.dBubble = mispred | (retHaz & ~loadUse);
                    ctrl.eBubble = mispred | loadUse;
                    ctrl.mBubble = excHaz;
                    ctrl.wStall  = (bus.W_stat_i != STAT_AOK);
                    ctrl.setCc   = (bus.E_icode_i == I_OPQ) & ~excHaz;
                end
                PC_INIT: begin
                end
                default: begin
                    ctrl.wStall = 1'b1;
                end
            endcase
        end
    end

    assign bus.F_stall_o  = ctrl.fStall;
    assign bus.D_stall_o  = ctrl.dStall;
    assign bus.D_bubble_o = ctrl.dBubble;
    assign bus.E_bubble_o = ctrl.eBubble;
    assign bus.M_bubble_o = ctrl.mBubble;
    assign bus.W_stall_o  = ctrl.wStall;
    assign bus.set_cc_o   = ctrl.setCc;
    assign bus.cpu_stat_o = cpuStat_q;

    sat_cnt #(.CNT_W(CNT_W)) uCycCnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (running),
        .cnt_o (bus.cyc_cnt_o)
    );

    sat_cnt #(.CNT_W(CNT_W)) uStallCnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (running & ctrl.fStall),
        .cnt_o (bus.stall_cnt_o)
    );

    sat_cnt #(.CNT_W(CNT_W)) uMispredCnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (running & mispred),
        .cnt_o (bus.mispred_cnt_o)
    );

endmodule
